// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one main-memory port between the instruction-cache refill path (I)
// and the data-cache load/store path (D). One-word transactions, one owner
// at a time, with a timeout guard on the memory handshake.
//
// Data traffic wins by default. A saturating streak counter forces an I grant
// once D has won MAX_D_STREAK times in a row while I was waiting, so that
// instruction fetch always makes progress.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | port free, arbitrate between i_req and d_req every cycle
//   BUS     | owner's transaction presented on mem_*, waiting for mem_ack
//   RESP    | one-cycle done (and err) pulse to the owner, req inputs ignored

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 2,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYC);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  // The timer counts down from this value; reaching zero in BUS marks the
  // TIMEOUT_CYC-th cycle without an ack.
  localparam logic [TMO_W-1:0]    TMO_LOAD   = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_nxt;

  logic                grant_i;
  logic                grant_d;
  logic                bus_ack;
  logic                bus_tmo;

  logic                owner_d_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [STREAK_W-1:0] streak_q;

  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                i_done_q;
  logic                d_done_q;
  logic                i_err_q;
  logic                d_err_q;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic: arbitration in IDLE, ack/timeout resolution in BUS.
  // An ack arriving on the last timer cycle still counts as a success.
  always_comb begin
    state_nxt = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    bus_ack   = 1'b0;
    bus_tmo   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_req && !(i_req && (streak_q == STREAK_MAX))) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end
        if (grant_d || grant_i) begin
          state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        if (mem_ack) begin
          bus_ack   = 1'b1;
          state_nxt = ST_RESP;
        end else if (tmo_q == '0) begin
          bus_tmo   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the winning transaction; I never writes, so its we/wdata are zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (grant_d) begin
      owner_d_q <= 1'b1;
      we_q      <= d_we;
      addr_q    <= d_addr;
      wdata_q   <= d_wdata;
    end else if (grant_i) begin
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= i_addr;
      wdata_q   <= '0;
    end
  end

  // Timeout down-counter, reloaded on every grant and run while in BUS.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (grant_d || grant_i) begin
      tmo_q <= TMO_LOAD;
    end else if ((state_q == ST_BUS) && (tmo_q != '0)) begin
      tmo_q <= tmo_q - 1'b1;
    end
  end

  // Streak of D grants taken while I was waiting; saturates at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else if (grant_i) begin
      streak_q <= '0;
    end else if (grant_d) begin
      if (!i_req) begin
        streak_q <= '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_q <= streak_q + 1'b1;
      end
    end
  end

  // Capture read data for the owner on ack; stores and timeouts leave it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (bus_ack) begin
      if (!owner_d_q) begin
        i_rdata_q <= mem_rdata;
      end else if (!we_q) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Done/err pulses are registered so they line up exactly with RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      i_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      i_done_q <= (bus_ack || bus_tmo) && !owner_d_q;
      d_done_q <= (bus_ack || bus_tmo) &&  owner_d_q;
      i_err_q  <= bus_tmo && !owner_d_q;
      d_err_q  <= bus_tmo &&  owner_d_q;
    end
  end

  // Outputs decode registered state only; nothing reaches mem_* from req.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    mem_req   = (state_q == ST_BUS);
    mem_we    = mem_req && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_gnt     = busy && !owner_d_q;
    d_gnt     = busy &&  owner_d_q;
    i_done    = i_done_q;
    d_done    = d_done_q;
    i_err     = i_err_q;
    d_err     = d_err_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a randomized
// run checked against a transaction-timeline reference model.

module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 2;
  localparam int TMO  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_done, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_done, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ack, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] last_d_rd;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
    .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; mem_ack = 0; mem_rdata = '0;
    tick(); tick();
    n_checks++;
    if ({i_gnt, i_done, i_err, d_gnt, d_done, d_err, mem_req, mem_we, busy} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000000",
        {i_gnt, i_done, i_err, d_gnt, d_done, d_err, mem_req, mem_we, busy});
    end
    n_checks++;
    if ((mem_addr !== '0) || (mem_wdata !== '0)) begin
      n_fail++; $display("FAIL reset_mem: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if ((i_rdata !== '0) || (d_rdata !== '0)) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0", i_rdata, d_rdata);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got busy %b expected 0", busy);
    end
    last_d_rd = '0;
  endtask

  task automatic test_lone_fetch();
    i_req = 1; i_addr = 32'h40;
    tick();
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if ({mem_req, mem_we, i_gnt, d_gnt} !== 4'b1010 || mem_addr !== 32'h40) begin
        n_fail++; $display("FAIL fetch_bus%0d: got req/we/ig/dg %b addr %h expected 1010 addr 40",
          k, {mem_req, mem_we, i_gnt, d_gnt}, mem_addr);
      end
      if (k == 3) begin mem_ack = 1; mem_rdata = 32'h00500093; end
      else        begin mem_rdata = $urandom; end
      tick();
    end
    mem_ack = 0;
    n_checks++;
    if ({i_done, i_err, mem_req} !== 3'b100 || i_rdata !== 32'h00500093) begin
      n_fail++; $display("FAIL fetch_done: got done/err/req %b rdata %h expected 100 rdata 00500093",
        {i_done, i_err, mem_req}, i_rdata);
    end
    i_req = 0;
    tick();
    n_checks++;
    if ({i_done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_after: got done/busy %b expected 00", {i_done, busy});
    end
  endtask

  task automatic test_store_then_fetch();
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hBEEF;
    i_req = 1; i_addr = 32'h80;
    tick();
    n_checks++;
    if ({d_gnt, i_gnt, mem_we} !== 3'b101 || mem_addr !== 32'h10 || mem_wdata !== 32'hBEEF) begin
      n_fail++; $display("FAIL store_bus: got dg/ig/we %b addr %h wdata %h expected 101 10 BEEF",
        {d_gnt, i_gnt, mem_we}, mem_addr, mem_wdata);
    end
    mem_ack = 1; mem_rdata = 32'h7777_0000;
    tick();
    mem_ack = 0;
    n_checks++;
    if ({d_done, d_err, i_done} !== 3'b100 || d_rdata !== last_d_rd) begin
      n_fail++; $display("FAIL store_done: got done/err/idone %b rdata %h expected 100 rdata %h",
        {d_done, d_err, i_done}, d_rdata, last_d_rd);
    end
    d_req = 0; d_we = 0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL store_idle: got busy %b expected 0", busy);
    end
    tick();
    n_checks++;
    if ({i_gnt, d_gnt, mem_we} !== 3'b100 || mem_addr !== 32'h80) begin
      n_fail++; $display("FAIL fetch2_bus: got ig/dg/we %b addr %h expected 100 addr 80",
        {i_gnt, d_gnt, mem_we}, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 0;
    n_checks++;
    if (i_done !== 1'b1 || i_rdata !== 32'h1111_2222) begin
      n_fail++; $display("FAIL fetch2_done: got done %b rdata %h expected 1 11112222", i_done, i_rdata);
    end
    i_req = 0;
    tick();
  endtask

  task automatic test_streak();
    int streak = 0;
    bit exp_d;
    logic [DW-1:0] data;
    i_req = 1; d_req = 1; d_we = 0; i_addr = $urandom; d_addr = $urandom;
    for (int g = 0; g < 9; g++) begin
      exp_d = (streak != MAXS);
      tick();
      n_checks++;
      if (d_gnt !== exp_d || i_gnt !== !exp_d || mem_addr !== (exp_d ? d_addr : i_addr)) begin
        n_fail++; $display("FAIL streak_grant%0d: got dg %b ig %b addr %h expected dg %b",
          g, d_gnt, i_gnt, mem_addr, exp_d);
      end
      data = $urandom; mem_ack = 1; mem_rdata = data;
      tick();
      mem_ack = 0;
      n_checks++;
      if (exp_d ? (d_done !== 1'b1 || d_rdata !== data) : (i_done !== 1'b1 || i_rdata !== data)) begin
        n_fail++; $display("FAIL streak_done%0d: got id %b dd %b ird %h drd %h expected data %h",
          g, i_done, d_done, i_rdata, d_rdata, data);
      end
      if (exp_d) begin last_d_rd = data; d_addr = $urandom; streak++; end
      else       begin i_addr = $urandom; streak = 0; end
      if (g == 8) begin i_req = 0; d_req = 0; end
      tick();
    end
  endtask

  task automatic test_timeout();
    d_req = 1; d_we = 0; d_addr = 32'h20; mem_ack = 0;
    tick();
    for (int k = 0; k < TMO; k++) begin
      n_checks++;
      if (mem_req !== 1'b1 || d_done !== 1'b0) begin
        n_fail++; $display("FAIL tmo_bus%0d: got req %b done %b expected 1 0", k, mem_req, d_done);
      end
      mem_rdata = $urandom;
      tick();
    end
    n_checks++;
    if ({mem_req, d_done, d_err} !== 3'b011 || d_rdata !== last_d_rd) begin
      n_fail++; $display("FAIL tmo_done: got req/done/err %b rdata %h expected 011 rdata %h",
        {mem_req, d_done, d_err}, d_rdata, last_d_rd);
    end
    d_req = 0;
    tick();
    n_checks++;
    if ({d_done, d_err, busy} !== 3'b000) begin
      n_fail++; $display("FAIL tmo_after: got done/err/busy %b expected 000", {d_done, d_err, busy});
    end
  endtask

  task automatic test_reset_mid_bus();
    i_req = 1; i_addr = 32'h44;
    tick(); tick();
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: got req %b expected 1", mem_req);
    end
    reset = 1'b0; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({mem_req, busy, i_gnt, i_done, d_gnt} !== 5'b0 || i_rdata !== '0) begin
      n_fail++; $display("FAIL rst_async: got req/busy/ig/id/dg %b rdata %h expected 00000 0",
        {mem_req, busy, i_gnt, i_done, d_gnt}, i_rdata);
    end
    i_req = 0;
    tick();
    mem_ack = 0; reset = 1'b1;
    last_d_rd = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({i_done, d_done, busy} !== 3'b000) begin
        n_fail++; $display("FAIL rst_nodone%0d: got id/dd/busy %b expected 000", k, {i_done, d_done, busy});
      end
    end
    d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    n_checks++;
    if ({mem_req, d_gnt} !== 2'b11 || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL rst_fresh_bus: got req/dg %b addr %h expected 11 200", {mem_req, d_gnt}, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'hCAFE_0002;
    tick();
    mem_ack = 0;
    n_checks++;
    if ({d_done, d_err} !== 2'b10 || d_rdata !== 32'hCAFE_0002) begin
      n_fail++; $display("FAIL rst_fresh_done: got done/err %b rdata %h expected 10 CAFE0002",
        {d_done, d_err}, d_rdata);
    end
    last_d_rd = 32'hCAFE_0002;
    d_req = 0;
    tick();
  endtask

  task automatic test_spurious_ack();
    mem_ack = 1; mem_rdata = 32'h5151_5151;
    tick(); tick();
    mem_ack = 0;
    n_checks++;
    if ({busy, d_done, i_done} !== 3'b000 || d_rdata !== last_d_rd) begin
      n_fail++; $display("FAIL spur_idle: got busy/dd/id %b rdata %h expected 000 rdata %h",
        {busy, d_done, i_done}, d_rdata, last_d_rd);
    end
    d_req = 1; d_we = 0; d_addr = 32'h300;
    tick(); tick();
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL spur_bus: got req %b expected 1", mem_req);
    end
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 0;
    n_checks++;
    if (d_done !== 1'b1 || d_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL spur_load: got done %b rdata %h expected 1 12345678", d_done, d_rdata);
    end
    d_req = 0;
    tick();
  endtask

  // Reference model: each grant fixes a timeline (bus window, done cycle,
  // next arbitration cycle) from the documented latencies.
  task automatic test_random();
    int next_arb = 0, bus_start = 0, bus_end = 0, done_c = 0, lat = 0, streak = 0;
    bit active = 0, own_d = 0, exp_we = 0, i_pend = 0, d_pend = 0;
    bit in_bus, in_own, is_done;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0, ack_data = '0, exp_i_rd = '0, exp_d_rd = '0;
    i_req = 0; d_req = 0; mem_ack = 0; reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int c = 0; c < 600; c++) begin
      in_bus  = active && (c >= bus_start) && (c <= bus_end);
      in_own  = active && (c >= bus_start) && (c <= done_c);
      is_done = active && (c == done_c);
      if (is_done && lat != 0) begin
        if (!own_d) exp_i_rd = ack_data;
        else if (!exp_we) exp_d_rd = ack_data;
      end
      n_checks++;
      if ({mem_req, busy, i_gnt, d_gnt} !== {in_bus, in_own, in_own && !own_d, in_own && own_d}) begin
        n_fail++; $display("FAIL rnd_ctrl c=%0d: got req/busy/ig/dg %b expected %b", c,
          {mem_req, busy, i_gnt, d_gnt}, {in_bus, in_own, in_own && !own_d, in_own && own_d});
      end
      n_checks++;
      if ({i_done, i_err, d_done, d_err} !== {is_done && !own_d, is_done && !own_d && lat == 0,
                                              is_done && own_d, is_done && own_d && lat == 0}) begin
        n_fail++; $display("FAIL rnd_done c=%0d: got id/ie/dd/de %b lat %0d own_d %b", c,
          {i_done, i_err, d_done, d_err}, lat, own_d);
      end
      n_checks++;
      if (i_rdata !== exp_i_rd || d_rdata !== exp_d_rd) begin
        n_fail++; $display("FAIL rnd_rdata c=%0d: got %h/%h expected %h/%h", c,
          i_rdata, d_rdata, exp_i_rd, exp_d_rd);
      end
      if (in_bus) begin
        n_checks++;
        if (mem_addr !== exp_addr || mem_we !== exp_we || mem_wdata !== exp_wdata) begin
          n_fail++; $display("FAIL rnd_bus c=%0d: got %h/%b/%h expected %h/%b/%h", c,
            mem_addr, mem_we, mem_wdata, exp_addr, exp_we, exp_wdata);
        end
      end
      if (is_done) begin
        active = 0;
        if (own_d) d_pend = 0; else i_pend = 0;
      end
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
      i_req = i_pend; d_req = d_pend;
      if (!active && c == next_arb) begin
        if (d_pend && !(i_pend && streak == MAXS)) begin
          active = 1; own_d = 1; exp_addr = d_addr; exp_we = d_we; exp_wdata = d_wdata;
          streak = i_pend ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end else if (i_pend) begin
          active = 1; own_d = 0; exp_addr = i_addr; exp_we = 0; exp_wdata = '0;
          streak = 0;
        end
        if (active) begin
          lat       = $urandom_range(0, TMO);
          bus_start = c + 1;
          bus_end   = bus_start + ((lat != 0) ? lat - 1 : TMO - 1);
          done_c    = bus_end + 1;
          next_arb  = bus_end + 2;
          ack_data  = $urandom;
        end else begin
          next_arb = c + 1;
        end
      end
      if (active && lat != 0 && c == bus_end) begin
        mem_ack = 1; mem_rdata = ack_data;
      end else if (active && c >= bus_start && c <= bus_end) begin
        mem_ack = 0; mem_rdata = $urandom;
      end else begin
        mem_ack = 1'($urandom_range(0, 7) == 0); mem_rdata = $urandom;
      end
      tick();
    end
    i_req = 0; d_req = 0; mem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store_then_fetch();
    test_streak();
    test_timeout();
    test_reset_mid_bus();
    test_spurious_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared main-memory port behind the pipeline's instruction and data caches. The instruction-cache refill path (I) and the data-cache load-miss / write-through-store path (D) each issue one-word transactions. The block grants one requester at a time and drives the memory-side valid/ack handshake with a timeout guard. It returns read data plus a one-cycle completion pulse to the owner. Data traffic has priority; a bounded streak counter guarantees instruction fetch forward progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 2, consecutive D grants allowed while I is waiting (≥1)
- TIMEOUT_CYC, 64, cycles in BUS without mem_ack before abort (≥2)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- i_req  in  1  instruction-side request, held until i_done
- i_addr  in  ADDR_W  instruction word address
- i_gnt  out  1  I owns the port (BUS or RESP)
- i_done  out  1  one-cycle completion pulse to I
- i_err  out  1  valid with i_done: transaction timed out
- i_rdata  out  DATA_W  read data, valid with i_done
- d_req  in  1  data-side request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  D owns the port
- d_done  out  1  one-cycle completion pulse to D
- d_err  out  1  valid with d_done: timed out
- d_rdata  out  DATA_W  load data, valid with d_done
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: arbitration is sampled each cycle.
  - D wins if d_req is high, unless i_req is high and streak == MAX_D_STREAK; in that case I wins.
  - I wins if only i_req is high.
  - On a win: latch owner, addr, we, wdata (we and wdata forced to 0 for I); clear the timeout counter; go to BUS.
- BUS: mem_req = 1; mem_we, mem_addr, mem_wdata come from the latched values and are stable for the whole state.
  - mem_ack = 1: capture mem_rdata into the owner's rdata register (loads/fetches only), clear err; go to RESP.
  - Timeout counter reaches TIMEOUT_CYC-1 without ack: set err, leave rdata unchanged; go to RESP.
- RESP: owner's done = 1 and err as set; mem_req = 0; go to IDLE unconditionally.
  - req inputs are ignored in RESP.
- Stores: d_rdata is not updated.
- Streak counter (saturating at MAX_D_STREAK):
  - +1 on a D grant with i_req high.
  - Cleared on an I grant.
  - Cleared on a D grant with i_req low.
- Requester rule: deassert req (or present a new transaction) on the edge that ends the done cycle. Arbitration samples req in IDLE only, so a stale req is never re-granted.
- mem_ack while not in BUS is ignored.
- Reset (reset = 0), asynchronous, regardless of state:
  - state IDLE; streak and timeout counters 0.
  - All outputs 0, including rdata registers, mem_* and busy.
  - An in-flight transaction is dropped with no done pulse; requesters reissue after reset.

## Timing
- Request seen in IDLE at cycle N → BUS from N+1 (mem_req high).
- mem_ack at cycle M ≥ N+1 → done at M+1 → IDLE at M+2.
- Minimum req-to-done latency: 2 cycles; minimum issue interval: 3 cycles.
- Timeout: done with err = 1 at cycle N+1+TIMEOUT_CYC.
- gnt is high during BUS and RESP for the owner only; i_gnt and d_gnt are never both high.
- done and err are registered pulses, exactly one cycle.
- Outputs are registered or decoded from registered state; no combinational path from req inputs to mem_*.

## Test plan
- Lone I fetch, addr 0x40, memory acks 3 cycles after mem_req → mem_req for 3 cycles with mem_we = 0; i_done 1 cycle later with i_rdata = mem_rdata (0x00500093); i_err = 0.
- D store (d_we = 1, addr 0x10, wdata 0xBEEF) simultaneous with an I request → D granted first, mem_we = 1 with 0xBEEF; I granted in the IDLE that follows d_done.
- d_req and i_req held continuously with MAX_D_STREAK = 2 → grant order D, D, I, D, D, I…; streak never exceeds 2.
- No mem_ack with TIMEOUT_CYC = 4 → mem_req high exactly 4 cycles, then d_done = 1, d_err = 1, d_rdata unchanged.
- reset driven to 0 mid-BUS → mem_req, busy, gnt and done drop to 0 immediately with no done pulse; after release, a fresh request completes normally.
- mem_ack pulsed while IDLE, then a normal load → spurious ack ignored; the load returns the later mem_rdata.
